// File: rtl/jpeg_zzrle_pkg.sv
// Shared types and constants for the zig-zag / run-length symbol generator.
package jpeg_zzrle_pkg;

  // Natural index (row*8+col) for each zig-zag scan position.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StEval,
    StEmit,
    StZrl,
    StEob
  } state_e;

  typedef struct packed {
    logic        dc;
    logic [3:0]  run;
    logic [3:0]  size;
    logic [10:0] amp;
  } sym_t;

  localparam logic signed [16:0] DC_LIM = 17'sd2047;
  localparam logic signed [16:0] AC_LIM = 17'sd1023;

  function automatic logic signed [11:0] clamp12(input logic signed [16:0] v,
                                                 input logic signed [16:0] lim);
    logic signed [16:0] nlim;
    nlim = -lim;
    if (v > lim) begin
      return lim[11:0];
    end else if (v < nlim) begin
      return nlim[11:0];
    end else begin
      return v[11:0];
    end
  endfunction

endpackage

// File: rtl/jpeg_zzrle_vli.sv
// jpeg_vli: JPEG variable-length-integer size/amplitude of a 12-bit signed value.
module jpeg_vli (
  input  logic signed [11:0] v_i,
  output logic [3:0]         size_o,
  output logic [10:0]        amp_o
);

  logic [11:0] w_mag;
  logic [11:0] w_vm1;
  logic [11:0] w_mask;

  assign w_mag = v_i[11] ? -v_i : v_i;

  always_comb begin
    size_o = '0;
    for (int i = 0; i < 11; i++) begin
      if (w_mag[i]) size_o = 4'(i + 1);
    end
  end

  // Negative values carry the one's-complement form, trimmed to size bits.
  assign w_vm1  = v_i - 12'sd1;
  assign w_mask = (12'd1 << size_o) - 12'd1;
  assign amp_o  = v_i[11] ? (w_vm1[10:0] & w_mask[10:0]) : v_i[10:0];

endmodule

// File: rtl/jpeg_zzrle.sv
// jpeg_zzrle: zig-zag scan of one quantized 8x8 block into DC/AC/ZRL/EOB symbols.
// Define JPEG_ZZRLE_DCPRED_EN to code DC as a difference against the previous block.
module jpeg_zzrle
  import jpeg_zzrle_pkg::*;
#(
  parameter int unsigned COEF_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        dc_clr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        mem_en_o,
  output logic [4:0]  mem_addr_o,
  input  logic [31:0] mem_dat_i,
  output logic        sym_valid_o,
  input  logic        sym_ready_i,
  output logic        sym_dc_o,
  output logic [3:0]  sym_run_o,
  output logic [3:0]  sym_size_o,
  output logic [10:0] sym_amp_o
);

  state_e      r_state;
  logic [5:0]  r_idx;
  logic [5:0]  r_run;
  sym_t        r_sym;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_mem_en;
  logic [4:0]  r_mem_addr;
  logic [3:0]  r_ac_size;
  logic [10:0] r_ac_amp;

  logic                     w_sel;
  logic [4:0]               w_addr_nxt;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [16:0]       w_coef_ext;
  logic [15:0]              w_pred;
  logic signed [16:0]       w_pred_ext;
  logic signed [16:0]       w_diff;
  logic                     w_is_dc;
  logic                     w_zero;
  logic signed [11:0]       w_vli_in;
  logic [3:0]               w_vli_size;
  logic [10:0]              w_vli_amp;
  logic                     w_hs;
  logic [5:0]               w_run_m16;

  assign w_sel      = ZZ[r_idx][0];
  assign w_addr_nxt = ZZ[r_idx + 6'd1][5:1];
  assign w_coef     = w_sel ? mem_dat_i[16 +: COEF_W] : mem_dat_i[0 +: COEF_W];
  assign w_coef_ext = {{(17 - COEF_W){w_coef[COEF_W-1]}}, w_coef};
  assign w_pred_ext = {w_pred[15], w_pred};
  assign w_diff     = w_coef_ext - w_pred_ext;
  assign w_is_dc    = (r_idx == 6'd0);
  assign w_zero     = (w_coef == '0);
  assign w_vli_in   = w_is_dc ? clamp12(w_diff, DC_LIM) : clamp12(w_coef_ext, AC_LIM);
  assign w_hs       = r_valid & sym_ready_i;
  assign w_run_m16  = r_run - 6'd16;

  jpeg_vli u_vli (
    .v_i    (w_vli_in),
    .size_o (w_vli_size),
    .amp_o  (w_vli_amp)
  );

`ifdef JPEG_ZZRLE_DCPRED_EN
  logic [15:0] r_pred;

  // A clear wins over the update so a scan restart never inherits a stale DC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pred <= '0;
    end else if (dc_clr_i) begin
      r_pred <= '0;
    end else if (r_state == StEval && w_is_dc) begin
      r_pred <= w_coef_ext[15:0];
    end
  end

  assign w_pred = r_pred;
`else
  logic w_unused_dc_clr;

  assign w_unused_dc_clr = dc_clr_i;
  assign w_pred          = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_run      <= '0;
      r_sym      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      r_ac_size  <= '0;
      r_ac_amp   <= '0;
    end else begin
      r_done   <= 1'b0;
      r_mem_en <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_state    <= StRead;
            r_idx      <= '0;
            r_run      <= '0;
            r_busy     <= 1'b1;
            r_mem_en   <= 1'b1;
            r_mem_addr <= '0;
          end
        end
        StRead: r_state <= StEval;
        StEval: begin
          if (w_is_dc) begin
            r_state <= StEmit;
            r_valid <= 1'b1;
            r_sym   <= '{dc: 1'b1, run: 4'd0, size: w_vli_size, amp: w_vli_amp};
          end else if (w_zero) begin
            r_run <= r_run + 6'd1;
            if (r_idx == 6'd63) begin
              r_state <= StEob;
              r_valid <= 1'b1;
              r_sym   <= '0;
            end else begin
              r_idx      <= r_idx + 6'd1;
              r_state    <= StRead;
              r_mem_en   <= 1'b1;
              r_mem_addr <= w_addr_nxt;
            end
          end else begin
            // Keep the coded value aside while any ZRL symbols go out first.
            r_ac_size <= w_vli_size;
            r_ac_amp  <= w_vli_amp;
            r_valid   <= 1'b1;
            if (r_run > 6'd15) begin
              r_state <= StZrl;
              r_sym   <= '{dc: 1'b0, run: 4'hf, size: 4'd0, amp: 11'd0};
            end else begin
              r_state <= StEmit;
              r_sym   <= '{dc: 1'b0, run: r_run[3:0], size: w_vli_size, amp: w_vli_amp};
            end
          end
        end
        StZrl: begin
          if (w_hs) begin
            r_run <= w_run_m16;
            if (w_run_m16 <= 6'd15) begin
              r_state <= StEmit;
              r_sym   <= '{dc: 1'b0, run: w_run_m16[3:0], size: r_ac_size, amp: r_ac_amp};
            end
          end
        end
        StEmit: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_sym   <= '0;
            r_run   <= '0;
            if (r_idx == 6'd63) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx      <= r_idx + 6'd1;
              r_state    <= StRead;
              r_mem_en   <= 1'b1;
              r_mem_addr <= w_addr_nxt;
            end
          end
        end
        StEob: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_sym   <= '0;
            r_state <= StIdle;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign mem_en_o    = r_mem_en;
  assign mem_addr_o  = r_mem_addr;
  assign sym_valid_o = r_valid;
  assign sym_dc_o    = r_sym.dc;
  assign sym_run_o   = r_sym.run;
  assign sym_size_o  = r_sym.size;
  assign sym_amp_o   = r_sym.amp;

endmodule
